// File: rtl/uart_rx_byte_pkg.sv
// Shared types and constants for the 8N1 UART byte receiver.
// Imported by the receiver top level.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_state_e;

   localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
   localparam int unsigned UART_DATA_BITS       = 8;

endpackage

// File: rtl/uart_rx_byte_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Reset loads RST_VAL into both stages.
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver: oversampled start/data/stop recovery with
// a one-cycle byte strobe, sticky framing and overrun flags.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       out_akn,
   input  logic       clr_err,
   output logic       out_rdy,
   output logic [7:0] byte_out,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

   logic rx_s;

   uart_state_e               state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [2:0]                bit_q, bit_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic [UART_DATA_BITS-1:0] byte_q, byte_d;
   logic                      rdy_q, rdy_d;
   logic                      pend_q, pend_d;
   logic                      fe_q, fe_d;
   logic                      ov_q, ov_d;
   logic                      fe_set;
   logic                      ov_set;

   sync2 #(
      .RST_VAL(1'b1)
   ) u_sync_rx (
      .clk_i (clk),
      .rst_ni(rst),
      .d_i   (rx),
      .q_o   (rx_s)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         byte_q  <= '0;
         rdy_q   <= 1'b0;
         pend_q  <= 1'b0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         rdy_q   <= rdy_d;
         pend_q  <= pend_d;
         fe_q    <= fe_d;
         ov_q    <= ov_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      rdy_d   = 1'b0;
      fe_set  = 1'b0;
      ov_set  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == LAST_BIT) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  byte_d  = shift_q;
                  rdy_d   = 1'b1;
                  ov_set  = pend_q;
                  state_d = IDLE;
               end else begin
                  fe_set  = 1'b1;
                  state_d = BREAK;
               end
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A strobe and an acknowledge in the same cycle: the ack retires the older byte.
   always_comb begin
      pend_d = pend_q;
      if (rdy_q)        pend_d = 1'b1;
      else if (out_akn) pend_d = 1'b0;
      fe_d = fe_set | (fe_q & ~clr_err);
      ov_d = ov_set | (ov_q & ~clr_err);
   end

   assign out_rdy   = rdy_q;
   assign byte_out  = byte_q;
   assign frame_err = fe_q;
   assign overrun   = ov_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Randomized and directed bench for uart_rx_byte (CLKS_PER_BIT=16)
// against a timestamp-based frame model.
module tb_uart_rx_byte;

   localparam int N = 16;
   localparam int H = N / 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       out_akn;
   logic       clr_err;
   logic       out_rdy;
   logic [7:0] byte_out;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   always #5 clk = ~clk;

   uart_rx_byte #(
      .CLKS_PER_BIT(N)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .out_akn  (out_akn),
      .clr_err  (clr_err),
      .out_rdy  (out_rdy),
      .byte_out (byte_out),
      .frame_err(frame_err),
      .overrun  (overrun),
      .busy     (busy)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures < 40)
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   // Model: line as seen after two sync stages, frame events at fixed
   // offsets from the first low sample t.
   bit         m_live = 0;
   bit         m_s1, m_s2, m_frame, m_break, m_pend, m_rdy, m_fe, m_ov;
   logic [7:0] m_byte, m_acc;
   int         m_e = 0;
   int         m_t;

   always @(posedge clk) begin
      int d;
      bit s, fe_set, ov_set, rdy_n, pend_n;
      m_e++;
      if (!rst) begin
         m_live  = 1; m_s1 = 1; m_s2 = 1;
         m_frame = 0; m_break = 0; m_pend = 0;
         m_rdy   = 0; m_byte = 8'h00; m_fe = 0; m_ov = 0;
      end else if (m_live) begin
         s      = m_s2;
         fe_set = 0; ov_set = 0; rdy_n = 0;
         pend_n = m_rdy ? 1'b1 : (out_akn ? 1'b0 : m_pend);
         if (m_break) begin
            if (s) m_break = 0;
         end else if (!m_frame) begin
            if (!s) begin
               m_frame = 1;
               m_t     = m_e;
            end
         end else begin
            d = m_e - m_t;
            if (d == H) begin
               if (s) m_frame = 0;
            end else if (d > H && d < H + 9 * N && (d - H) % N == 0) begin
               m_acc[3'((d - H) / N - 1)] = s;
            end else if (d == H + 9 * N) begin
               m_frame = 0;
               if (s) begin
                  rdy_n  = 1;
                  m_byte = m_acc;
                  ov_set = m_pend;
               end else begin
                  fe_set  = 1;
                  m_break = 1;
               end
            end
         end
         m_fe   = fe_set | (m_fe & !clr_err);
         m_ov   = ov_set | (m_ov & !clr_err);
         m_rdy  = rdy_n;
         m_pend = pend_n;
         m_s2   = m_s1;
         m_s1   = rx;
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("out_rdy", 32'(out_rdy), 32'(m_rdy));
         chk("byte_out", 32'(byte_out), 32'(m_byte));
         chk("frame_err", 32'(frame_err), 32'(m_fe));
         chk("overrun", 32'(overrun), 32'(m_ov));
         chk("busy", 32'(busy), 32'(m_frame | m_break));
      end
   end

   int rdy_cnt  = 0;
   int rdy_cyc  = 0;
   int busy_cnt = 0;
   int akn_mode = 0;
   bit prev_rdy = 0;

   always @(negedge clk) begin
      if (out_rdy === 1'b1) begin
         rdy_cnt++;
         rdy_cyc = cyc;
      end
      if (busy === 1'b1) busy_cnt++;
      case (akn_mode)
         1:       out_akn = prev_rdy;
         2:       out_akn = ($urandom_range(0, 3) == 0);
         default: out_akn = 1'b0;
      endcase
      prev_rdy = (out_rdy === 1'b1);
   end

   int last_start;

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Start + 8 data bits with a period of p2/2 cycles, then the stop level.
   task automatic send(input logic [7:0] b, input int p2,
                       input logic stop_lvl, input int stop_cyc);
      int bi;
      last_start = cyc + 1;
      for (int c = 0; c < 10 * p2; c++) begin
         bi = (2 * c) / p2;
         if (bi >= 9) break;
         rx = (bi == 0) ? 1'b0 : b[bi-1];
         @(negedge clk);
      end
      rx = stop_lvl;
      repeat (stop_cyc) @(negedge clk);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int   n0;
      int   b0;
      int   p2;
      bit   bad;
      logic [7:0] rb;
      logic [7:0] rate_bytes [3];
      rate_bytes[0] = 8'h00;
      rate_bytes[1] = 8'hFF;
      rate_bytes[2] = 8'h55;
      rst = 1'b0; rx = 1'b1; clr_err = 1'b0; out_akn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rdy", 32'(out_rdy), 0);
      chk("rst_byte", 32'(byte_out), 0);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b1;
      idle(5);

      akn_mode = 1;
      n0 = rdy_cnt;
      send(8'hA5, 32, 1'b1, N);
      idle(10);
      chk("t1_count", 32'(rdy_cnt - n0), 1);
      chk("t1_byte", 32'(byte_out), 32'h A5);
      chk("t1_latency", 32'(rdy_cyc - last_start), 154);
      chk("t1_flags", {30'd0, frame_err, overrun}, 0);

      n0 = rdy_cnt;
      b0 = busy_cnt;
      rx = 1'b0;
      repeat (6) @(negedge clk);
      idle(40);
      chk("glitch_busy", 32'(busy_cnt - b0), 8);
      chk("glitch_rdy", 32'(rdy_cnt - n0), 0);

      n0 = rdy_cnt;
      send(8'h3C, 32, 1'b0, 3 * N);
      idle(N);
      chk("ferr_set", 32'(frame_err), 1);
      chk("ferr_rdy", 32'(rdy_cnt - n0), 0);
      chk("ferr_byte", 32'(byte_out), 32'h A5);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      @(negedge clk);
      chk("ferr_clr", 32'(frame_err), 0);
      n0 = rdy_cnt;
      send(8'h81, 32, 1'b1, N);
      idle(10);
      chk("t3_byte", 32'(byte_out), 32'h 81);
      chk("t3_count", 32'(rdy_cnt - n0), 1);

      akn_mode = 0;
      idle(4);
      n0 = rdy_cnt;
      send(8'h11, 32, 1'b1, N);
      send(8'h22, 32, 1'b1, N);
      idle(10);
      chk("b2b_count", 32'(rdy_cnt - n0), 2);
      chk("b2b_byte", 32'(byte_out), 32'h 22);
      chk("b2b_ovr", 32'(overrun), 1);

      akn_mode = 1;
      n0 = rdy_cnt;
      rx = 1'b0;
      repeat (N) @(negedge clk);
      rx = 1'b1;
      repeat (3 * N) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_rst_byte", 32'(byte_out), 0);
      chk("mid_rst_ovr", 32'(overrun), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      rst = 1'b1;
      idle(2 * N);
      chk("abort_rdy", 32'(rdy_cnt - n0), 0);
      send(8'h5A, 32, 1'b1, N);
      idle(10);
      chk("rst_5a", 32'(byte_out), 32'h 5A);

      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 2; j++) begin
            p2 = (j == 0) ? 31 : 33;
            n0 = rdy_cnt;
            send(rate_bytes[i], p2, 1'b1, p2 / 2 + 2);
            idle(3);
            chk("rate_byte", 32'(byte_out), 32'(rate_bytes[i]));
            chk("rate_count", 32'(rdy_cnt - n0), 1);
         end
      end

      akn_mode = 2;
      for (int k = 0; k < 40; k++) begin
         rb  = 8'($urandom);
         p2  = 31 + $urandom_range(0, 2);
         bad = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) begin
            clr_err = 1'b1;
            @(negedge clk);
            clr_err = 1'b0;
         end
         if ($urandom_range(0, 5) == 0) begin
            rx = 1'b0;
            repeat ($urandom_range(1, 7)) @(negedge clk);
            idle(12);
         end
         if (bad) send(rb, p2, 1'b0, N);
         else     send(rb, p2, 1'b1, p2 / 2 + $urandom_range(0, 8));
         idle($urandom_range(0, 10));
      end
      idle(50);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Serial-to-byte receiver that recovers 8N1 asynchronous frames from a single RX line and presents each received byte on the ready/acknowledge byte interface used by the byte-to-word assembler directly downstream. It is the front end of the serial ingest path. It oversamples the line with the system clock, validates start and stop bits, and flags framing errors and unacknowledged-byte overruns.

## Interface
- CLKS_PER_BIT, 868, system clock cycles per serial bit (100 MHz / 115200); legal range 4..65535
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-low
- rx  in  1  asynchronous serial line, idle high
- out_akn  in  1  downstream acknowledge of the current byte
- clr_err  in  1  synchronous clear of sticky error flags
- out_rdy  out  1  single-cycle strobe: byte_out holds a new byte
- byte_out  out  8  last received byte, held stable until the next byte
- frame_err  out  1  sticky: stop bit sampled low
- overrun  out  1  sticky: new byte completed before previous byte was acknowledged
- busy  out  1  high while a frame is being received (any state but IDLE)

## Operation
- rx passes through a 2-FF synchronizer. All decisions use the synchronized value rx_s.
- States:
  - IDLE: wait for rx_s high-to-low.
  - START: after CLKS_PER_BIT/2 (integer divide) cycles, re-sample. Low goes to DATA. High is a glitch: return to IDLE with no flag.
  - DATA: sample 8 bits, LSB first, one every CLKS_PER_BIT cycles, into the shift register.
  - STOP: sample after CLKS_PER_BIT cycles. High: load byte_out, pulse out_rdy, go to IDLE. Low: set frame_err, byte discarded (no out_rdy, byte_out unchanged), go to BREAK.
  - BREAK: wait until rx_s is high, then go to IDLE.
- Bit-timing counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each sample. The bit index is 3 bits.
- Acknowledge tracking: an internal pending flag sets on out_rdy and clears on any cycle with out_akn high. If out_rdy and out_akn coincide in one cycle, pending ends set; the acknowledge applies to the older byte.
- overrun sets when a valid stop bit completes while pending is still set. The new byte still replaces byte_out and still pulses out_rdy.
- clr_err clears frame_err and overrun. If a set event occurs in the same cycle, the set wins.
- out_rdy is a one-cycle pulse by design. The downstream assembler captures on every cycle its ready input is high, so a held ready would duplicate bytes.

## Timing
- Reset (rst=0 at an edge): state IDLE; out_rdy=0, byte_out=8'h00, frame_err=0, overrun=0, busy=0. Synchronizer flops are set to 1 (idle line), pending=0, counters=0.
- Reset mid-frame aborts the frame silently. Reception resumes on the next falling edge after rst returns high.
- Let t be the cycle in which rx_s is first seen low. Then:
  - start check at t+CLKS_PER_BIT/2
  - data bit i sampled at t+CLKS_PER_BIT/2+(i+1)·CLKS_PER_BIT
  - stop sampled at t+CLKS_PER_BIT/2+9·CLKS_PER_BIT
  - out_rdy high in the following cycle, with byte_out valid in that same cycle
- Pin-to-strobe latency is therefore t_pin + 2 (synchronizer) + the above.
- busy rises the cycle after t. It falls in the cycle out_rdy pulses, or in the cycle BREAK exits.
- Back-to-back frames: IDLE is re-entered with at least CLKS_PER_BIT/2 cycles of stop bit remaining. The next start edge is accepted from the first cycle in IDLE.
- A falling edge in IDLE within the remainder of the stop bit is treated as a start.

## Structure
- Package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP, BREAK} as logic [2:0]
  - localparam DEFAULT_CLKS_PER_BIT = 868
  - localparam UART_DATA_BITS = 8
- One sub-module, sync2: a 2-flop synchronizer with a reset value parameter, instantiated for rx. The FSM, counters and flags live in uart_rx_byte.

## Test plan
All directed cases run with CLKS_PER_BIT=16.
- Single frame 0xA5 at exact bit rate, out_akn tied to out_rdy delayed 1 cycle -> one out_rdy pulse, byte_out=8'hA5, 8+1.5 bit times after start edge plus 2 cycles, no flags set.
- 6-cycle low glitch on idle rx -> returns to IDLE, no out_rdy, busy high for exactly 8 cycles, no flags set.
- Frame 0x3C with stop bit held low for 3 bit times -> frame_err=1, no out_rdy, byte_out unchanged; clr_err pulse -> frame_err=0; next frame 0x81 received correctly.
- Frames 0x11 then 0x22 back-to-back, out_akn never asserted -> two out_rdy pulses, byte_out=8'h22, overrun=1 after the second pulse.
- Reset asserted mid-DATA of frame 0xFF, then frame 0x5A -> no out_rdy for the aborted frame, all outputs at reset values, then 8'h5A delivered.
- Frames at ±3% bit-rate error (periods of 15.5 and 16.5 cycles averaged) for bytes 0x00, 0xFF, 0x55 -> all received correctly.
